mac_tx_arbiter: RTL and testbench
=================================

// Module: mac_tx_arbiter
// PURPOSE
//  Packet-granular arbiter sharing the single 8-bit AXI-Stream TX input of the MAC frame encapsulator
//  among NUM_PORTS requesters (e.g. pause/control frames, host queues). Whole frames only; never interleaves.
//  Stall watchdog turns an upstream mid-frame underrun into a tuser-marked, tlast-terminated frame, then drains the source.
// PARAMETERS
//  NUM_PORTS    4    number of upstream requesters (2..8)
//  STALL_LIMIT  64   consecutive no-data cycles mid-frame before abort; 0 disables the watchdog
// PORTS
//  clk          in   1            single clock, all logic on posedge
//  reset        in   1            synchronous, active-high
//  s_tdata      in   8*NUM_PORTS  per-port data, port p at [8p+7:8p]
//  s_tvalid     in   NUM_PORTS    per-port valid
//  s_tready     out  NUM_PORTS    per-port ready
//  s_tuser      in   NUM_PORTS    per-port error flag, forwarded
//  s_tlast      in   NUM_PORTS    per-port end of frame
//  m_tdata      out  8            to encapsulator tdata
//  m_tvalid     out  1            to encapsulator tvalid
//  m_tready     in   1            from encapsulator tready
//  m_tuser      out  1            to encapsulator tuser
//  m_tlast      out  1            to encapsulator tlast
//  grant_idx    out  $clog2(NUM_PORTS)  port currently or last granted
//  busy         out  1            high in any state except IDLE
//  abort_pulse  out  1            one-cycle pulse when an aborted frame's terminating beat is accepted
// BEHAVIOUR
//  Reset: state=IDLE, s_tready=0, m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0, grant_idx=0, busy=0, abort_pulse=0,
//   last_grant=NUM_PORTS-1 (port 0 has first round-robin priority), stall_cnt=0. Reset mid-frame: no terminating beat.
//  IDLE: if any s_tvalid, pick winner = first requesting port after last_grant (rotating); register grant_idx -> XFER.
//   One bubble cycle between grant decision and first forwarded beat. No request: stay IDLE.
//  XFER: combinational pass-through, m_*=s_*[grant_idx]; s_tready[grant_idx]=m_tready, others 0.
//   m_tvalid&m_tready&m_tlast -> last_grant<=grant_idx, IDLE (next frame can be granted the following cycle).
//   stall_cnt increments each XFER cycle with s_tvalid[grant_idx]=0, clears on any cycle it is 1.
//   stall_cnt==STALL_LIMIT-1 with source still idle -> ABORT. A beat arriving in that same cycle wins: cnt clears, no abort.
//  ABORT: m_tvalid=1, m_tdata=8'h00, m_tuser=1, m_tlast=1; all s_tready=0. On m_tready: abort_pulse=1 for that cycle -> FLUSH.
//  FLUSH: m_tvalid=0; s_tready[grant_idx]=1; discard beats; s_tvalid&s_tlast -> last_grant<=grant_idx, IDLE.
//  Upstream tuser forwarded unchanged in XFER; arbiter never drops a frame except the remainder of an aborted one.
//  Widths: stall_cnt is $clog2(STALL_LIMIT+1) bits, saturating; grant_idx wraps NUM_PORTS-1 -> 0 in the rotation.
// CONFIGURATION
//  STRICT_PRIO_EN defined: port 0 wins every IDLE decision in which it requests; remaining ports round-robin as above.
//  Not defined: pure round-robin, all ports equal; last_grant updated identically in both builds.
// STRUCTURE
//  Package mac_pkg: arb_state_t enum {IDLE, XFER, ABORT, FLUSH}, MAC_DATA_W=8, MAC_ABORT_DATA=8'h00.
//  Sub-module mac_rr_pick: combinational rotating-priority picker (req vector, last_grant -> valid, index).
// TESTING
//  1. Ports 0,2 each hold a 60-byte frame from reset -> port 0 forwarded first, then port 2; no interleaving, 1 bubble each.
//  2. All 4 ports request continuously, 8 frames -> grant order 0,1,2,3,0,1,2,3 (STRICT_PRIO_EN undefined).
//  3. STRICT_PRIO_EN defined, ports 0 and 1 always requesting -> port 0 granted every frame.
//  4. Port 1 drops s_tvalid for 64 cycles after byte 20 -> beat {00,tuser=1,tlast=1}, abort_pulse once, rest of frame drained.
//  5. Port 1 resumes exactly at stall cycle 63 -> no abort, frame completes intact; m_tready toggled 50% -> no lost/duplicate bytes.
//  6. reset asserted mid-XFER -> next cycle all outputs at reset values; after release port 0 granted first.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the MAC TX arbiter slice.
//   arb_state_t       : arbiter FSM states (IDLE, XFER, ABORT, FLUSH)
//   MAC_DATA_W        : AXI-Stream byte lane width towards the encapsulator
//   MAC_ABORT_DATA    : data byte carried by the synthetic terminating beat
//   stall_cnt_width() : width of the stall watchdog counter for a given limit
// -----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2,
        FLUSH = 2'd3
    } arb_state_t;

    localparam int MAC_DATA_W = 8;
    localparam logic [MAC_DATA_W-1:0] MAC_ABORT_DATA = 8'h00;

    // A limit of 0 disables the watchdog; keep a 1-bit counter so the
    // register never collapses to zero width.
    function automatic int stall_cnt_width(input int limit);
        int w;
        if (limit > 0) begin
            w = $clog2(limit + 1);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage : mac_pkg

// File: rtl/mac_rr_pick.sv
// -----------------------------------------------------------------------------
// mac_rr_pick
// Combinational rotating-priority picker. The first requesting port strictly
// after last_grant_i (wrapping NUM_PORTS-1 -> 0) wins; last_grant_i itself
// has the lowest priority.
// Ports:
//   req_i        : per-port request vector
//   last_grant_i : port granted most recently
//   valid_o      : at least one request present
//   idx_o        : winning port index (0 when valid_o is low)
// -----------------------------------------------------------------------------
module mac_rr_pick #(
    parameter int NUM_PORTS = 4,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic                 valid_o,
    output logic [IDX_W-1:0]     idx_o
);

    int              cand_s;
    logic [IDX_W-1:0] cand_idx_s;

    // Scan from the farthest offset down to the nearest so the closest
    // requester after last_grant_i is the final (winning) assignment.
    always_comb begin
        valid_o    = 1'b0;
        idx_o      = '0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand_s     = (int'(last_grant_i) + k) % NUM_PORTS;
            cand_idx_s = IDX_W'(cand_s);
            if (req_i[cand_idx_s]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule : mac_rr_pick

// File: rtl/mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter
// Packet-granular arbiter sharing the 8-bit AXI-Stream TX input of the MAC
// frame encapsulator among NUM_PORTS requesters. Whole frames only, never
// interleaved. A stall watchdog turns a mid-frame upstream underrun into a
// tuser-marked, tlast-terminated beat and then drains the rest of that frame.
//
// Configuration macro:
//   STRICT_PRIO_EN : port 0 wins every arbitration in which it requests;
//                    otherwise (undefined) pure round-robin.
//
// Parameters:
//   NUM_PORTS   : number of requesters (2..8)
//   STALL_LIMIT : consecutive no-data cycles mid-frame before abort (0 = off)
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   s_tdata/tvalid/tuser/tlast, s_tready : per-port upstream AXI-Stream
//   m_tdata/tvalid/tuser/tlast, m_tready : stream towards the encapsulator
//   grant_idx            : port currently or last granted
//   busy                 : high in every state except IDLE
//   abort_pulse          : one cycle when the aborting beat is accepted
// -----------------------------------------------------------------------------
module mac_tx_arbiter
    import mac_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int STALL_LIMIT = 64,
    localparam int GW         = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [MAC_DATA_W*NUM_PORTS-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS-1:0]            s_tuser,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic [MAC_DATA_W-1:0]           m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tuser,
    output logic                            m_tlast,
    output logic [GW-1:0]                   grant_idx,
    output logic                            busy,
    output logic                            abort_pulse
);

    localparam int CW = stall_cnt_width(STALL_LIMIT);
    localparam logic [CW-1:0] STALL_LAST = CW'((STALL_LIMIT > 0) ? (STALL_LIMIT - 1) : 0);
    localparam logic          WDOG_EN    = (STALL_LIMIT > 0) ? 1'b1 : 1'b0;

    arb_state_t          state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [CW-1:0]       stall_cnt_q, stall_cnt_d;

    logic                rr_valid_s;
    logic [GW-1:0]       rr_idx_s;
    logic                win_valid_s;
    logic [GW-1:0]       win_idx_s;

    logic [MAC_DATA_W-1:0] src_data_s;
    logic                  src_valid_s;
    logic                  src_user_s;
    logic                  src_last_s;
    logic                  stall_hit_s;

    mac_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_i        (s_tvalid),
        .last_grant_i (last_grant_q),
        .valid_o      (rr_valid_s),
        .idx_o        (rr_idx_s)
    );

`ifdef STRICT_PRIO_EN
    // Port 0 overrides the rotation; the rotation pointer still advances
    // normally so the other ports keep their relative order.
    assign win_valid_s = rr_valid_s;
    assign win_idx_s   = s_tvalid[0] ? '0 : rr_idx_s;
`else
    assign win_valid_s = rr_valid_s;
    assign win_idx_s   = rr_idx_s;
`endif

    // Upstream lane currently owned by the grant.
    assign src_data_s  = s_tdata[MAC_DATA_W*grant_q +: MAC_DATA_W];
    assign src_valid_s = s_tvalid[grant_q];
    assign src_user_s  = s_tuser[grant_q];
    assign src_last_s  = s_tlast[grant_q];

    // Last idle cycle the watchdog tolerates; a beat in this cycle wins.
    assign stall_hit_s = WDOG_EN && (stall_cnt_q == STALL_LAST) && !src_valid_s;

    // State, grant pointers and watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        stall_cnt_d  = stall_cnt_q;
        s_tready     = '0;
        m_tdata      = '0;
        m_tvalid     = 1'b0;
        m_tuser      = 1'b0;
        m_tlast      = 1'b0;
        abort_pulse  = 1'b0;
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                stall_cnt_d = '0;
                if (win_valid_s) begin
                    grant_d = win_idx_s;
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end

            XFER: begin
                m_tdata           = src_data_s;
                m_tvalid          = src_valid_s;
                m_tuser           = src_user_s;
                m_tlast           = src_last_s;
                s_tready[grant_q] = m_tready;
                if (src_valid_s) begin
                    stall_cnt_d = '0;
                    if (m_tready && src_last_s) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end else if (stall_hit_s) begin
                    stall_cnt_d = '0;
                    state_d     = ABORT;
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end else begin
                    stall_cnt_d = stall_cnt_q;
                end
            end

            ABORT: begin
                // Synthetic terminating beat; upstream is held off meanwhile.
                m_tdata  = MAC_ABORT_DATA;
                m_tvalid = 1'b1;
                m_tuser  = 1'b1;
                m_tlast  = 1'b1;
                if (m_tready) begin
                    abort_pulse = 1'b1;
                    state_d     = FLUSH;
                end else begin
                    state_d = ABORT;
                end
            end

            FLUSH: begin
                // Swallow the remainder of the aborted frame.
                s_tready[grant_q] = 1'b1;
                if (src_valid_s && src_last_s) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_idx = grant_q;

endmodule : mac_tx_arbiter

// File: tb/tb_mac_tx_arbiter.sv
module tb_mac_tx_arbiter;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [8*NP-1:0] s_tdata;
    logic [NP-1:0]   s_tvalid;
    logic [NP-1:0]   s_tready;
    logic [NP-1:0]   s_tuser;
    logic [NP-1:0]   s_tlast;
    logic [7:0]      m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tuser;
    logic            m_tlast;
    logic [1:0]      grant_idx;
    logic            busy;
    logic            abort_pulse;

    mac_tx_arbiter #(.NUM_PORTS(NP), .STALL_LIMIT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tuser     (s_tuser),
        .s_tlast     (s_tlast),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tuser     (m_tuser),
        .m_tlast     (m_tlast),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .abort_pulse (abort_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Upstream source models
    int pos[NP];
    int len[NP];
    int stall_at[NP];
    int stall_rem[NP];
    bit active[NP];
    bit rpt[NP];
    bit err[NP];
    bit tready_toggle;

    // Observed output beats: {tuser, tlast, tdata}
    logic [9:0] log_beat[$];
    int         log_cyc[$];
    logic [1:0] log_grant[$];
    int         cyc;
    int         pulses;

    function automatic logic [9:0] exp_beat(input int p, input int j, input int l, input bit e);
        logic last;
        logic [7:0] d;
        last = (j == l - 1);
        d = 8'((p << 6) | (j & 63));
        return {e & last, last, d};
    endfunction

    function automatic bit any_active();
        bit a;
        a = 1'b0;
        for (int p = 0; p < NP; p++) a = a | active[p];
        return a;
    endfunction

    task automatic clear_sources();
        for (int p = 0; p < NP; p++) begin
            pos[p] = 0; len[p] = 1; stall_at[p] = -1; stall_rem[p] = 0;
            active[p] = 1'b0; rpt[p] = 1'b0; err[p] = 1'b0;
        end
        tready_toggle = 1'b0;
    endtask

    task automatic drive();
        bit hold;
        for (int p = 0; p < NP; p++) begin
            hold = active[p] && (pos[p] == stall_at[p]) && (stall_rem[p] > 0);
            if (hold) stall_rem[p] = stall_rem[p] - 1;
            s_tvalid[p]       = active[p] && !hold;
            s_tdata[8*p +: 8] = 8'((p << 6) | (pos[p] & 63));
            s_tlast[p]        = active[p] && (pos[p] == len[p] - 1);
            s_tuser[p]        = err[p] && active[p] && (pos[p] == len[p] - 1);
        end
        m_tready = tready_toggle ? cyc[0] : 1'b1;
    endtask

    task automatic start();
        cyc = 0;
        pulses = 0;
        log_beat.delete();
        log_cyc.delete();
        log_grant.delete();
        drive();
    endtask

    task automatic step();
        bit adv[NP];
        @(negedge clk);
        if (m_tvalid && m_tready) begin
            log_beat.push_back({m_tuser, m_tlast, m_tdata});
            log_cyc.push_back(cyc);
            log_grant.push_back(grant_idx);
        end
        if (abort_pulse) pulses++;
        for (int p = 0; p < NP; p++) adv[p] = s_tvalid[p] && s_tready[p];
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (adv[p]) begin
                if (s_tlast[p]) begin
                    pos[p] = 0;
                    if (!rpt[p]) active[p] = 1'b0;
                end else begin
                    pos[p] = pos[p] + 1;
                end
            end
        end
        cyc++;
        drive();
    endtask

    task automatic run_until_idle(input int maxc, input string nm);
        bit done;
        done = 1'b0;
        for (int k = 0; k < maxc && !done; k++) begin
            step();
            done = !any_active() && !busy;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, maxc);
        end
    endtask

    task automatic run_frames(input int nfr, input int maxc, input string nm);
        int lasts;
        lasts = 0;
        for (int k = 0; k < maxc && lasts < nfr; k++) begin
            step();
            lasts = 0;
            foreach (log_beat[i]) if (log_beat[i][8]) lasts++;
        end
        if (lasts < nfr) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: %0d frames seen, required %0d", nm, lasts, nfr);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_sources();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_sources();
        active[1] = 1'b1; len[1] = 4;
        cyc = 0;
        drive();
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
        n_cmp++; if (m_tdata !== 8'h00) begin n_fail++; $display("FAIL rst_m_tdata: got %h want 00", m_tdata); end
        n_cmp++; if (m_tuser !== 1'b0) begin n_fail++; $display("FAIL rst_m_tuser: got %b want 0", m_tuser); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast: got %b want 0", m_tlast); end
        n_cmp++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL rst_s_tready: got %b want 0000", s_tready); end
        n_cmp++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL rst_grant: got %0d want 0", grant_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (abort_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_abort: got %b want 0", abort_pulse); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_sources();
        drive();
    endtask

    task automatic test_two_frames();
        logic [9:0] e;
        int p;
        apply_reset();
        active[0] = 1'b1; len[0] = 60;
        active[2] = 1'b1; len[2] = 60; err[2] = 1'b1;
        start();
        run_until_idle(400, "two_frames");
        n_cmp++;
        if (log_beat.size() != 120) begin
            n_fail++; $display("FAIL two_frames_count: got %0d beats want 120", log_beat.size());
        end
        for (int i = 0; i < 120 && i < log_beat.size(); i++) begin
            p = (i < 60) ? 0 : 2;
            e = exp_beat(p, i % 60, 60, err[p]);
            n_cmp++;
            if (log_beat[i] !== e) begin
                n_fail++; $display("FAIL two_frames_beat%0d: got %h want %h", i, log_beat[i], e);
            end
        end
        if (log_beat.size() >= 61) begin
            n_cmp++;
            if (log_cyc[0] != 1) begin n_fail++; $display("FAIL two_frames_first_cyc: got %0d want 1", log_cyc[0]); end
            n_cmp++;
            if (log_cyc[60] != 62) begin n_fail++; $display("FAIL two_frames_second_cyc: got %0d want 62", log_cyc[60]); end
        end
    endtask

    task automatic test_round_robin();
        int order[8];
        logic [9:0] e;
`ifdef STRICT_PRIO_EN
        order = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        apply_reset();
        for (int p = 0; p < NP; p++) begin active[p] = 1'b1; rpt[p] = 1'b1; len[p] = 4; end
        start();
        run_frames(8, 300, "round_robin");
        n_cmp++;
        if (log_beat.size() < 32) begin
            n_fail++; $display("FAIL rr_count: got %0d beats want at least 32", log_beat.size());
        end
        for (int i = 0; i < 32 && i < log_beat.size(); i++) begin
            e = exp_beat(order[i / 4], i % 4, 4, 1'b0);
            n_cmp++;
            if (log_beat[i] !== e || log_grant[i] !== 2'(order[i / 4])) begin
                n_fail++; $display("FAIL rr_beat%0d: got %h grant %0d want %h grant %0d",
                                   i, log_beat[i], log_grant[i], e, order[i / 4]);
            end
        end
    endtask

    task automatic test_two_requesters();
        int order[6];
        logic [9:0] e;
`ifdef STRICT_PRIO_EN
        order = '{0, 0, 0, 0, 0, 0};
`else
        order = '{0, 1, 0, 1, 0, 1};
`endif
        apply_reset();
        for (int p = 0; p < 2; p++) begin active[p] = 1'b1; rpt[p] = 1'b1; len[p] = 3; end
        start();
        run_frames(6, 200, "prio");
        for (int i = 0; i < 18 && i < log_beat.size(); i++) begin
            e = exp_beat(order[i / 3], i % 3, 3, 1'b0);
            n_cmp++;
            if (log_beat[i] !== e) begin
                n_fail++; $display("FAIL prio_beat%0d: got %h want %h", i, log_beat[i], e);
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] e;
        apply_reset();
        active[1] = 1'b1; len[1] = 40; stall_at[1] = 20; stall_rem[1] = 64;
        start();
        run_until_idle(300, "abort");
        n_cmp++;
        if (log_beat.size() != 21) begin
            n_fail++; $display("FAIL abort_count: got %0d beats want 21", log_beat.size());
        end
        for (int i = 0; i < 20 && i < log_beat.size(); i++) begin
            e = exp_beat(1, i, 40, 1'b0);
            n_cmp++;
            if (log_beat[i] !== e) begin n_fail++; $display("FAIL abort_beat%0d: got %h want %h", i, log_beat[i], e); end
        end
        if (log_beat.size() >= 21) begin
            n_cmp++;
            if (log_beat[20] !== 10'h300) begin n_fail++; $display("FAIL abort_term_beat: got %h want 300", log_beat[20]); end
            n_cmp++;
            if (log_cyc[20] != 85) begin n_fail++; $display("FAIL abort_term_cyc: got %0d want 85", log_cyc[20]); end
        end
        n_cmp++;
        if (pulses != 1) begin n_fail++; $display("FAIL abort_pulses: got %0d want 1", pulses); end
        n_cmp++;
        if (active[1] !== 1'b0) begin n_fail++; $display("FAIL abort_drain: source still active, want drained"); end
    endtask

    task automatic test_resume();
        logic [9:0] e;
        apply_reset();
        active[1] = 1'b1; len[1] = 40; stall_at[1] = 20; stall_rem[1] = 63;
        tready_toggle = 1'b1;
        start();
        run_until_idle(400, "resume");
        n_cmp++;
        if (log_beat.size() != 40) begin
            n_fail++; $display("FAIL resume_count: got %0d beats want 40", log_beat.size());
        end
        for (int i = 0; i < 40 && i < log_beat.size(); i++) begin
            e = exp_beat(1, i, 40, 1'b0);
            n_cmp++;
            if (log_beat[i] !== e) begin n_fail++; $display("FAIL resume_beat%0d: got %h want %h", i, log_beat[i], e); end
        end
        n_cmp++;
        if (pulses != 0) begin n_fail++; $display("FAIL resume_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        active[2] = 1'b1; len[2] = 40;
        start();
        repeat (10) step();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_m_tvalid: got %b want 0", m_tvalid); end
        n_cmp++; if (m_tdata !== 8'h00) begin n_fail++; $display("FAIL mid_m_tdata: got %h want 00", m_tdata); end
        n_cmp++; if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin
            n_fail++; $display("FAIL mid_m_last_user: got %b%b want 00", m_tlast, m_tuser);
        end
        n_cmp++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL mid_s_tready: got %b want 0000", s_tready); end
        n_cmp++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL mid_grant: got %0d want 0", grant_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_sources();
        active[0] = 1'b1; len[0] = 4;
        active[2] = 1'b1; len[2] = 4;
        start();
        run_until_idle(100, "mid_after");
        n_cmp++;
        if (log_beat.size() != 8) begin n_fail++; $display("FAIL mid_after_count: got %0d want 8", log_beat.size()); end
        for (int i = 0; i < 8 && i < log_beat.size(); i++) begin
            e = exp_beat((i < 4) ? 0 : 2, i % 4, 4, 1'b0);
            n_cmp++;
            if (log_beat[i] !== e) begin n_fail++; $display("FAIL mid_after_beat%0d: got %h want %h", i, log_beat[i], e); end
        end
    endtask

    initial begin
        s_tdata  = '0;
        s_tvalid = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        reset    = 1'b1;
        cyc      = 0;
        pulses   = 0;
        test_reset();
        test_two_frames();
        test_round_robin();
        test_two_requesters();
        test_abort();
        test_resume();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mac_tx_arbiter
